// File: rtl/vga_frame_checker.sv
// ---------------------------------------------------------------------------
// vga_frame_checker
//
// Passive sink for a VGA timing generator. It watches hsync/vsync/rgb on
// pixel_tick samples, measures line and frame timing against the configured
// geometry, sums the visible RGB of each frame, and raises sticky flags for
// timing or blanking violations. 'locked' reports whether the most recently
// closed frame was error-free.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   pixel_tick   pixel-rate enable; inputs are only sampled when high
//   hsync/vsync  syncs under test (asserted level = SYNC_POL)
//   rgb          12-bit pixel colour under test
//   locked       last closed frame had no errors
//   frame_done   one-clk pulse, one clk after the closing sample
//   frame_sum    sum of visible rgb over the last closed frame
//   frame_count  number of closed frames (wraps)
//   err_hline    a line was not H_TOTAL ticks long
//   err_hsync_w  an hsync pulse was not H_SYNC ticks wide
//   err_vframe   a frame was not V_TOTAL lines long
//   err_vsync_w  a vsync pulse did not span V_SYNC hsync edges
//   err_blank    non-zero rgb seen outside the visible window
// ---------------------------------------------------------------------------
module vga_frame_checker #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_TOTAL  = 525,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic [15:0] frame_count,
  output logic        err_hline,
  output logic        err_hsync_w,
  output logic        err_vframe,
  output logic        err_vsync_w,
  output logic        err_blank
);

  // Window bounds in 11 bits so a saturated 10-bit counter + 1 cannot alias.
  localparam logic [10:0] HV_LO  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HV_HI  = 11'(H_SYNC + H_BP + H_VIS);
  localparam logic [10:0] VV_LO  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] VV_HI  = 11'(V_SYNC + V_BP + V_VIS);
  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [9:0]  HS_END = 10'(H_SYNC - 1);
  localparam logic [9:0]  VS_W   = 10'(V_SYNC);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // State
  state_e      state_q,       state_d;
  logic        hs_prev_q,     hs_prev_d;
  logic        vs_prev_q,     vs_prev_d;
  logic [9:0]  hcnt_q,        hcnt_d;
  logic [9:0]  lcnt_q,        lcnt_d;
  logic [9:0]  vs_lines_q,    vs_lines_d;
  logic        seen_h_q,      seen_h_d;
  logic        seen_v_q,      seen_v_d;
  logic [31:0] acc_q,         acc_d;
  logic        frame_err_q,   frame_err_d;
  logic        locked_q,      locked_d;
  logic        frame_done_q,  frame_done_d;
  logic [31:0] frame_sum_q,   frame_sum_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        err_hline_q,   err_hline_d;
  logic        err_hsync_w_q, err_hsync_w_d;
  logic        err_vframe_q,  err_vframe_d;
  logic        err_vsync_w_q, err_vsync_w_d;
  logic        err_blank_q,   err_blank_d;

  // Per-sample decode
  logic hs_act, vs_act, h_lead, h_trail, v_lead, vis;
  logic e_hline, e_hsync_w, e_vframe, e_vsync_w, e_blank, e_any;

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    vs_lines_d    = vs_lines_q;
    seen_h_d      = seen_h_q;
    seen_v_d      = seen_v_q;
    acc_d         = acc_q;
    frame_err_d   = frame_err_q;
    locked_d      = locked_q;
    frame_done_d  = 1'b0;
    frame_sum_d   = frame_sum_q;
    frame_count_d = frame_count_q;
    err_hline_d   = err_hline_q;
    err_hsync_w_d = err_hsync_w_q;
    err_vframe_d  = err_vframe_q;
    err_vsync_w_d = err_vsync_w_q;
    err_blank_d   = err_blank_q;

    hs_act    = (hsync == SYNC_POL);
    vs_act    = (vsync == SYNC_POL);
    h_lead    = 1'b0;
    h_trail   = 1'b0;
    v_lead    = 1'b0;
    vis       = 1'b0;
    e_hline   = 1'b0;
    e_hsync_w = 1'b0;
    e_vframe  = 1'b0;
    e_vsync_w = 1'b0;
    e_blank   = 1'b0;
    e_any     = 1'b0;

    if (pixel_tick) begin
      h_lead  = hs_act && (hs_prev_q != SYNC_POL);
      h_trail = !hs_act && (hs_prev_q == SYNC_POL);
      v_lead  = vs_act && (vs_prev_q != SYNC_POL);

      hs_prev_d = hsync;
      vs_prev_d = vsync;

      // Pixel and line position of this sample
      hcnt_d = h_lead ? 10'd0 : sat_inc(hcnt_q);
      if (v_lead)      lcnt_d = h_lead ? 10'd1 : 10'd0;
      else if (h_lead) lcnt_d = sat_inc(lcnt_q);

      // Line checks use the pre-sample count, i.e. the length so far.
      if (seen_h_q && h_lead && (({1'b0, hcnt_q} + 11'd1) != H_TOT)) e_hline = 1'b1;
      if (seen_h_q && h_trail && (hcnt_q != HS_END))                e_hsync_w = 1'b1;
      seen_h_d = seen_h_q | h_lead;
      seen_v_d = seen_v_q | v_lead;

      // hsync edges seen while vsync is asserted; restarts at each vsync
      // edge, counting an hsync edge that coincides with it.
      if (v_lead)                vs_lines_d = (h_lead && vs_act) ? 10'd1 : 10'd0;
      else if (h_lead && vs_act) vs_lines_d = sat_inc(vs_lines_q);

      vis = seen_v_d &&
            ({1'b0, hcnt_d} >= HV_LO) && ({1'b0, hcnt_d} < HV_HI) &&
            ({1'b0, lcnt_d} >= VV_LO) && ({1'b0, lcnt_d} < VV_HI);

      if (vis)              acc_d   = acc_q + {20'd0, rgb};
      else if (rgb != 12'd0) e_blank = 1'b1;

      // Frame close checks; the closing sample itself belongs to no frame's
      // visible area, so frame_sum takes the accumulator as it stood.
      if (v_lead && (state_q != SEARCH)) begin
        if (({1'b0, lcnt_q} + {10'd0, h_lead}) != V_TOT) e_vframe  = 1'b1;
        if (vs_lines_q != VS_W)                          e_vsync_w = 1'b1;
      end

      e_any = e_hline | e_hsync_w | e_vframe | e_vsync_w | e_blank;

      err_hline_d   = err_hline_q   | e_hline;
      err_hsync_w_d = err_hsync_w_q | e_hsync_w;
      err_vframe_d  = err_vframe_q  | e_vframe;
      err_vsync_w_d = err_vsync_w_q | e_vsync_w;
      err_blank_d   = err_blank_q   | e_blank;
      frame_err_d   = frame_err_q   | e_any;

      if (v_lead) begin
        acc_d       = 32'd0;
        frame_err_d = 1'b0;
        case (state_q)
          SEARCH: state_d = MEASURE;
          default: begin
            frame_sum_d   = acc_q;
            frame_count_d = frame_count_q + 16'd1;
            frame_done_d  = 1'b1;
            locked_d      = !(frame_err_q | e_any);
            state_d       = (frame_err_q | e_any) ? MEASURE : LOCKED;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= ~SYNC_POL;
      vs_prev_q     <= ~SYNC_POL;
      hcnt_q        <= 10'd0;
      lcnt_q        <= 10'd0;
      vs_lines_q    <= 10'd0;
      seen_h_q      <= 1'b0;
      seen_v_q      <= 1'b0;
      acc_q         <= 32'd0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_sum_q   <= 32'd0;
      frame_count_q <= 16'd0;
      err_hline_q   <= 1'b0;
      err_hsync_w_q <= 1'b0;
      err_vframe_q  <= 1'b0;
      err_vsync_w_q <= 1'b0;
      err_blank_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      vs_lines_q    <= vs_lines_d;
      seen_h_q      <= seen_h_d;
      seen_v_q      <= seen_v_d;
      acc_q         <= acc_d;
      frame_err_q   <= frame_err_d;
      locked_q      <= locked_d;
      frame_done_q  <= frame_done_d;
      frame_sum_q   <= frame_sum_d;
      frame_count_q <= frame_count_d;
      err_hline_q   <= err_hline_d;
      err_hsync_w_q <= err_hsync_w_d;
      err_vframe_q  <= err_vframe_d;
      err_vsync_w_q <= err_vsync_w_d;
      err_blank_q   <= err_blank_d;
    end
  end

  assign locked      = locked_q;
  assign frame_done  = frame_done_q;
  assign frame_sum   = frame_sum_q;
  assign frame_count = frame_count_q;
  assign err_hline   = err_hline_q;
  assign err_hsync_w = err_hsync_w_q;
  assign err_vframe  = err_vframe_q;
  assign err_vsync_w = err_vsync_w_q;
  assign err_blank   = err_blank_q;

endmodule

// File: tb/tb_vga_frame_checker.sv
// ---------------------------------------------------------------------------
// Directed bench for vga_frame_checker. The checker runs with a shrunken
// geometry (16 ticks x 12 lines, 8x5 visible) so whole frames fit in a few
// thousand clocks; each 640x480 scenario is reproduced at that scale:
// "801-tick line" -> H_TOTAL+1, "95-tick hsync" -> H_SYNC-1,
// "526 lines / 3-line vsync" -> V_TOTAL+1 / V_SYNC+1, and the ideal frame sum
// 640*480*15 becomes 8*5*15 = 600.
// ---------------------------------------------------------------------------
module tb_vga_frame_checker;

  localparam int HVIS = 8, HS = 3, HBP = 2, HT = 16;
  localparam int VVIS = 5, VS = 2, VBP = 2, VT = 12;
  localparam int HV0 = HS + HBP;
  // vsync is raised on the last tick of the previous line, so the checker's
  // line number is generator row + 1; visible rows start one earlier.
  localparam int VR0 = VS + VBP - 1;
  localparam logic [31:0] SUM = 32'd600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixel_tick = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rgb = 12'd0;
  logic        locked, frame_done;
  logic [31:0] frame_sum;
  logic [15:0] frame_count;
  logic        err_hline, err_hsync_w, err_vframe, err_vsync_w, err_blank;
  logic [4:0]  errs;

  int n_chk = 0, n_pass = 0, done_cnt = 0;
  logic last_done = 1'b0;

  always #5 clk = ~clk;

  vga_frame_checker #(
    .H_VIS(HVIS), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
    .V_VIS(VVIS), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .frame_done(frame_done), .frame_sum(frame_sum),
    .frame_count(frame_count),
    .err_hline(err_hline), .err_hsync_w(err_hsync_w), .err_vframe(err_vframe),
    .err_vsync_w(err_vsync_w), .err_blank(err_blank)
  );

  assign errs = {err_hline, err_hsync_w, err_vframe, err_vsync_w, err_blank};

  // Counts clocks with frame_done high; a pulse wider than 1 clk over-counts.
  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One pixel sample: a tick clock followed by a non-tick clock.
  task automatic tick(input logic hs, input logic vs, input logic [11:0] px);
    @(negedge clk);
    hsync = hs; vsync = vs; rgb = px; pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
    last_done = frame_done;
  endtask

  // A few blank samples, then the vsync leading edge that opens a frame.
  task automatic preroll();
    repeat (3) tick(1'b1, 1'b1, 12'd0);
    tick(1'b1, 1'b0, 12'd0);
  endtask

  // One frame; a row argument of -1 disables that fault. The frame ends with
  // the vsync leading edge that opens the next one.
  task automatic frame(input int nlines, input int vs_lines, input int long_row,
                       input int short_row, input int blip_row, input int max_ticks);
    int n;
    n = 0;
    for (int vc = 0; vc < nlines; vc++) begin
      int len, hsw;
      len = (vc == long_row) ? HT + 1 : HT;
      hsw = (vc == short_row) ? HS - 1 : HS;
      for (int hc = 0; hc < len; hc++) begin
        logic hs, vs;
        logic [11:0] px;
        if (n == max_ticks) return;
        n++;
        hs = (hc < hsw) ? 1'b0 : 1'b1;
        vs = ((vc < vs_lines) && !((vc == vs_lines - 1) && (hc == len - 1))) ||
             ((vc == nlines - 1) && (hc == len - 1)) ? 1'b0 : 1'b1;
        px = (vc >= VR0 && vc < VR0 + VVIS && hc >= HV0 && hc < HV0 + HVIS) ? 12'h00F : 12'h000;
        if (vc == blip_row && hc == HT - 2) px = 12'h001;
        tick(hs, vs, px);
      end
    end
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("reset locked", locked, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_sum", frame_sum, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset errs", errs, 0);

    // 1: two ideal frames (three vsync edges)
    preroll();
    idle(1);
    chk("search no done", done_cnt, 0);
    frame(VT, VS, -1, -1, -1, 1 << 20);
    chk("f1 done latency", last_done, 1);
    frame(VT, VS, -1, -1, -1, 1 << 20);
    idle(1);
    chk("f2 done pulses", done_cnt, 2);
    chk("f2 frame_count", frame_count, 2);
    chk("f2 frame_sum", frame_sum, SUM);
    chk("f2 locked", locked, 1);
    chk("f2 errs", errs, 5'b00000);

    // 2: one long line, then a clean frame relocks
    frame(VT, VS, 5, -1, -1, 1 << 20);
    idle(1);
    chk("f3 errs", errs, 5'b10000);
    chk("f3 locked", locked, 0);
    chk("f3 frame_count", frame_count, 3);
    frame(VT, VS, -1, -1, -1, 1 << 20);
    idle(1);
    chk("f4 locked", locked, 1);
    chk("f4 errs", errs, 5'b10000);

    // 3: one narrow hsync pulse
    frame(VT, VS, -1, 6, -1, 1 << 20);
    idle(1);
    chk("f5 errs", errs, 5'b11000);
    chk("f5 locked", locked, 0);

    // 4: stray colour in the front porch
    frame(VT, VS, -1, -1, 4, 1 << 20);
    idle(1);
    chk("f6 errs", errs, 5'b11001);
    chk("f6 frame_sum", frame_sum, SUM);
    chk("f6 locked", locked, 0);

    // 5: one line too many and a 3-line vsync
    frame(VT + 1, VS + 1, -1, -1, -1, 1 << 20);
    idle(1);
    chk("f7 errs", errs, 5'b11111);
    chk("f7 locked", locked, 0);
    chk("f7 frame_count", frame_count, 7);
    chk("f7 done pulses", done_cnt, 7);

    // 6: reset mid-frame, then sync/rgb toggles without a tick
    frame(VT, VS, -1, -1, -1, 20);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("rst frame_count", frame_count, 0);
    chk("rst frame_sum", frame_sum, 0);
    chk("rst errs", errs, 0);
    chk("rst locked", locked, 0);
    @(negedge clk); hsync = 1'b0; vsync = 1'b0; rgb = 12'hFFF;
    @(negedge clk); hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
    preroll();
    idle(1);
    chk("post-rst first edge count", frame_count, 0);
    chk("post-rst first edge pulses", done_cnt, 7);
    chk("post-rst no-tick errs", errs, 0);
    frame(VT, VS, -1, -1, -1, 1 << 20);
    idle(1);
    chk("post-rst frame_count", frame_count, 1);
    chk("post-rst pulses", done_cnt, 8);
    chk("post-rst locked", locked, 1);
    chk("post-rst frame_sum", frame_sum, SUM);
    chk("post-rst errs", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
